// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the mul/div sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_PREP = 2'd1,
    MD_RUN  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  function automatic logic op_is_signed(md_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decode/execute <-> mul/div sequencer request and HI/LO result bundle.
interface muldiv_ctrl_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              md_i_ce;
  logic [1:0]        md_i_op;
  logic [DWIDTH-1:0] md_i_data_rs;
  logic [DWIDTH-1:0] md_i_data_rt;
  logic              md_i_wr_hi;
  logic              md_i_wr_lo;
  logic              md_i_flush;
  logic [DWIDTH-1:0] md_o_hi;
  logic [DWIDTH-1:0] md_o_lo;
  logic              md_o_busy;
  logic              md_o_done;

  modport master (
    output md_i_ce, md_i_op, md_i_data_rs, md_i_data_rt, md_i_wr_hi, md_i_wr_lo, md_i_flush,
    input  md_o_hi, md_o_lo, md_o_busy, md_o_done
  );

  modport slave (
    input  md_i_ce, md_i_op, md_i_data_rs, md_i_data_rt, md_i_wr_hi, md_i_wr_lo, md_i_flush,
    output md_o_hi, md_o_lo, md_o_busy, md_o_done
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step, chosen by mode_div.
module muldiv_step #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic                  mode_div,
  input  logic [2*DWIDTH-1:0]   mcand,
  input  logic [DWIDTH-1:0]     opb,
  input  logic [2*DWIDTH-1:0]   acc,
  output logic [2*DWIDTH-1:0]   mcand_nxt,
  output logic [DWIDTH-1:0]     opb_nxt,
  output logic [2*DWIDTH-1:0]   acc_nxt
);
  localparam int unsigned N = DWIDTH;

  logic [N:0] trial;

  always_comb begin
    // Remainder after the shift can need N+1 bits; the trial's top bit is the borrow.
    trial     = acc[2*N-1:N-1] - {1'b0, opb};
    mcand_nxt = mcand;
    opb_nxt   = opb;
    acc_nxt   = acc;
    if (mode_div) begin
      if (!trial[N]) begin
        acc_nxt = {trial[N-1:0], acc[N-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[2*N-2:0], 1'b0};
      end
    end else begin
      acc_nxt   = opb[0] ? acc + mcand : acc;
      mcand_nxt = mcand << 1;
      opb_nxt   = opb >> 1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer holding HI/LO; stalls the pipeline while busy.
// Define MULDIV_EARLY_OUT_EN to let a multiply finish once the remaining multiplier is zero.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic          es_clk,
  input  logic          es_rst,
  muldiv_ctrl_if.slave  md
);
  localparam int unsigned N = DWIDTH;
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DWIDTH - 1);

  md_state_e          state_q;
  md_op_e             op_q;
  logic [2*N-1:0]     a_q;
  logic [N-1:0]       b_q;
  logic [2*N-1:0]     acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic               neg_q;
  logic               rneg_q;
  logic               dz_q;
  logic [N-1:0]       hi_q;
  logic [N-1:0]       lo_q;
  logic               busy_q;
  logic               done_q;

  logic               is_div;
  logic               sign_rs;
  logic               sign_rt;
  logic [N-1:0]       rs_abs;
  logic [N-1:0]       rt_abs;
  logic [2*N-1:0]     prod_fix;
  logic [N-1:0]       quot_fix;
  logic [N-1:0]       rem_fix;
  logic [2*N-1:0]     step_a;
  logic [N-1:0]       step_b;
  logic [2*N-1:0]     step_acc;
  logic               early_out;

  always_comb begin
    is_div   = op_is_div(op_q);
    sign_rs  = op_is_signed(op_q) & a_q[N-1];
    sign_rt  = op_is_signed(op_q) & b_q[N-1];
    rs_abs   = sign_rs ? -a_q[N-1:0] : a_q[N-1:0];
    rt_abs   = sign_rt ? -b_q : b_q;
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
    rem_fix  = rneg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
  end

  muldiv_step #(
    .DWIDTH(N)
  ) u_step (
    .mode_div (is_div),
    .mcand    (a_q),
    .opb      (b_q),
    .acc      (acc_q),
    .mcand_nxt(step_a),
    .opb_nxt  (step_b),
    .acc_nxt  (step_acc)
  );

`ifdef MULDIV_EARLY_OUT_EN
  // The product never shifts, so once the multiplier is exhausted it is final.
  assign early_out = !is_div && (step_b == '0);
`else
  assign early_out = 1'b0;
`endif

  always_ff @(posedge es_clk or negedge es_rst) begin
    if (!es_rst) begin
      state_q <= MD_IDLE;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (md.md_i_flush && (state_q != MD_IDLE)) begin
        state_q <= MD_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          MD_IDLE: begin
            if (md.md_i_wr_hi) hi_q <= md.md_i_data_rs;
            if (md.md_i_wr_lo) lo_q <= md.md_i_data_rs;
            if (md.md_i_ce && !md.md_i_flush) begin
              op_q    <= md_op_e'(md.md_i_op);
              a_q     <= {{N{1'b0}}, md.md_i_data_rs};
              b_q     <= md.md_i_data_rt;
              busy_q  <= 1'b1;
              state_q <= MD_PREP;
            end
          end
          MD_PREP: begin
            cnt_q  <= '0;
            neg_q  <= sign_rs ^ sign_rt;
            rneg_q <= sign_rs;
            if (is_div && (b_q == '0)) begin
              // Raw rs stays in a_q so HI can report it untouched.
              dz_q    <= 1'b1;
              state_q <= MD_FIX;
            end else begin
              dz_q    <= 1'b0;
              a_q     <= {{N{1'b0}}, rs_abs};
              b_q     <= rt_abs;
              acc_q   <= is_div ? {{N{1'b0}}, rs_abs} : '0;
              state_q <= MD_RUN;
            end
          end
          MD_RUN: begin
            a_q   <= step_a;
            b_q   <= step_b;
            acc_q <= step_acc;
            cnt_q <= cnt_q + 1'b1;
            if ((cnt_q == CntLast) || early_out) state_q <= MD_FIX;
          end
          MD_FIX: begin
            if (dz_q) begin
              hi_q <= a_q[N-1:0];
              lo_q <= '1;
            end else if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*N-1:N];
              lo_q <= prod_fix[N-1:0];
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MD_IDLE;
          end
          default: state_q <= MD_IDLE;
        endcase
      end
    end
  end

  assign md.md_o_hi   = hi_q;
  assign md.md_o_lo   = lo_q;
  assign md.md_o_busy = busy_q;
  assign md.md_o_done = done_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (honours MULDIV_EARLY_OUT_EN latencies).
module tb_muldiv_ctrl;
  localparam int unsigned DW = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic es_clk;
  logic es_rst;
  int   n_checks;
  int   n_fails;

  muldiv_ctrl_if #(.DWIDTH(DW)) md ();

  muldiv_ctrl #(
    .DWIDTH   (DW),
    .CNT_WIDTH(6)
  ) dut (
    .es_clk(es_clk),
    .es_rst(es_rst),
    .md    (md)
  );

  initial es_clk = 1'b0;
  always #5 es_clk = ~es_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
    @(negedge es_clk);
    md.md_i_ce      = 1'b1;
    md.md_i_op      = op;
    md.md_i_data_rs = rs;
    md.md_i_data_rt = rt;
    @(negedge es_clk);
    md.md_i_ce = 1'b0;
  endtask

  // Counts edges after the accept edge until done; bounded so a dead DUT still ends.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!md.md_o_done && lat < 200) begin
      if (!md.md_o_busy) busy_ok = 1'b0;
      @(negedge es_clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [DW-1:0] rs,
                        input logic [DW-1:0] rt, input int exp_lat,
                        input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
    int lat;
    bit busy_ok;
    start(op, rs, rt);
    wait_done(lat, busy_ok);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    check({tag, " busy_end"}, 64'(md.md_o_busy), 64'd0);
    check({tag, " hi"}, 64'(md.md_o_hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(md.md_o_lo), 64'(exp_lo));
    @(negedge es_clk);
    check({tag, " done_pulse"}, 64'(md.md_o_done), 64'd0);
  endtask

  initial begin
    int  lat;
    bit  busy_ok;
    bit  seen;
    n_checks = 0;
    n_fails  = 0;
    es_rst = 1'b0;
    md.md_i_ce = 1'b0;
    md.md_i_op = 2'd0;
    md.md_i_data_rs = '0;
    md.md_i_data_rt = '0;
    md.md_i_wr_hi = 1'b0;
    md.md_i_wr_lo = 1'b0;
    md.md_i_flush = 1'b0;
    #1;
    check("rst hi", 64'(md.md_o_hi), 64'd0);
    check("rst lo", 64'(md.md_o_lo), 64'd0);
    check("rst busy", 64'(md.md_o_busy), 64'd0);
    check("rst done", 64'(md.md_o_done), 64'd0);
    @(negedge es_clk);
    es_rst = 1'b1;

    // MTHI in idle
    @(negedge es_clk);
    md.md_i_wr_hi = 1'b1;
    md.md_i_data_rs = 32'h0000_1234;
    @(negedge es_clk);
    md.md_i_wr_hi = 1'b0;
    check("mthi hi", 64'(md.md_o_hi), 64'h1234);
    check("mthi lo", 64'(md.md_o_lo), 64'd0);

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFF9, 32'd6, Early ? 5 : 34, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0, 2, 32'd100, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);
    run_op("divu_1000_7", 2'd3, 32'd1000, 32'd7, 34, 32'd6, 32'd142);
    run_op("multu_3x5", 2'd1, 32'd3, 32'd5, Early ? 5 : 34, 32'd0, 32'd15);

    // Flush in RUN at counter 10: HI/LO keep 0/15, no done
    start(2'd3, 32'h55, 32'd3);
    seen = 1'b0;
    repeat (11) begin
      if (md.md_o_done) seen = 1'b1;
      @(negedge es_clk);
    end
    md.md_i_flush = 1'b1;
    @(negedge es_clk);
    md.md_i_flush = 1'b0;
    check("flush busy", 64'(md.md_o_busy), 64'd0);
    check("flush hi", 64'(md.md_o_hi), 64'd0);
    check("flush lo", 64'(md.md_o_lo), 64'd15);
    repeat (3) begin
      if (md.md_o_done || md.md_o_busy) seen = 1'b1;
      @(negedge es_clk);
    end
    check("flush no_done", 64'(seen), 64'd0);
    run_op("after_flush", 2'd1, 32'd2, 32'd3, Early ? 4 : 34, 32'd0, 32'd6);

    // MTLO and a second request while busy are both ignored
    start(2'd1, 32'd4, 32'd5);
    @(negedge es_clk);
    md.md_i_wr_lo = 1'b1;
    md.md_i_data_rs = 32'hDEAD;
    md.md_i_ce = 1'b1;
    md.md_i_op = 2'd3;
    @(negedge es_clk);
    md.md_i_wr_lo = 1'b0;
    md.md_i_ce = 1'b0;
    check("busy_mtlo lo", 64'(md.md_o_lo), 64'd6);
    wait_done(lat, busy_ok);
    check("busy_ops latency", 64'(lat + 2), 64'(Early ? 5 : 34));
    check("busy_ops lo", 64'(md.md_o_lo), 64'd20);
    @(negedge es_clk);
    check("busy_ops no_second", 64'(md.md_o_busy), 64'd0);

    // MTHI coinciding with accept: write lands, result overwrites it
    @(negedge es_clk);
    md.md_i_ce = 1'b1;
    md.md_i_wr_hi = 1'b1;
    md.md_i_op = 2'd1;
    md.md_i_data_rs = 32'd7;
    md.md_i_data_rt = 32'd2;
    @(negedge es_clk);
    md.md_i_ce = 1'b0;
    md.md_i_wr_hi = 1'b0;
    check("ce_mthi hi", 64'(md.md_o_hi), 64'd7);
    check("ce_mthi busy", 64'(md.md_o_busy), 64'd1);
    wait_done(lat, busy_ok);
    check("ce_mthi res_hi", 64'(md.md_o_hi), 64'd0);
    check("ce_mthi res_lo", 64'(md.md_o_lo), 64'd14);

    // Flush with ce in idle: nothing accepted
    @(negedge es_clk);
    md.md_i_ce = 1'b1;
    md.md_i_flush = 1'b1;
    @(negedge es_clk);
    md.md_i_ce = 1'b0;
    md.md_i_flush = 1'b0;
    check("idle_flush busy", 64'(md.md_o_busy), 64'd0);

    // Async reset mid-RUN
    start(2'd3, 32'd1000, 32'd7);
    repeat (5) @(negedge es_clk);
    #2 es_rst = 1'b0;
    #1;
    check("arst hi", 64'(md.md_o_hi), 64'd0);
    check("arst lo", 64'(md.md_o_lo), 64'd0);
    check("arst busy", 64'(md.md_o_busy), 64'd0);
    check("arst done", 64'(md.md_o_done), 64'd0);
    @(negedge es_clk);
    es_rst = 1'b1;
    @(negedge es_clk);
    check("arst stays_idle", 64'(md.md_o_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
